// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: a prescaled step strobe advances a chase, bounce,
// binary count or fill pattern on the LED bank, with step and wrap pulses.
module led_pattern_gen #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    COUNT  = 2'd2,
    FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } bdir_e;

  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [WIDTH-1:0] LSB   = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB   = LSB << (WIDTH - 1);
  localparam logic [KW-1:0]    K_MAX = KW'(WIDTH);

  mode_e            mode_q, mode_d, mode_in;
  bdir_e            bdir_q, bdir_d;
  logic [CW-1:0]    cnt_q, cnt_d, last_cnt;
  logic [WIDTH-1:0] led_q, led_d, fill_next;
  logic [KW-1:0]    k_q, k_d, k_next;
  logic             step_q, step_d, wrap_q, wrap_d;

  always_comb begin
    mode_in  = mode_e'(mode);
    last_cnt = CW'((TICK_DIV >> speed) - 1);
    mode_d   = mode_q;
    bdir_d   = bdir_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    k_d      = k_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;

    k_next    = (k_q == K_MAX) ? '0 : k_q + 1'b1;
    // Thermometer of k_next ones, packed at the LSB end or the MSB end
    fill_next = dir ? ~(ONES >> k_next) : ~(ONES << k_next);

    if (mode_in != mode_q) begin
      mode_d = mode_in;
      cnt_d  = '0;
      bdir_d = UP;
      k_d    = '0;
      unique case (mode_in)
        CHASE:   led_d = dir ? MSB : LSB;
        BOUNCE:  led_d = LSB;
        default: led_d = '0;
      endcase
    end else if (!pause) begin
      // >= lets a speed increase strobe immediately instead of overrunning
      if (cnt_q >= last_cnt) begin
        cnt_d  = '0;
        step_d = 1'b1;
        unique case (mode_q)
          CHASE: begin
            if (dir) begin
              led_d  = {led_q[0], led_q[WIDTH-1:1]};
              wrap_d = led_q[0];
            end else begin
              led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              wrap_d = led_q[WIDTH-1];
            end
          end
          BOUNCE: begin
            if (bdir_q == UP) begin
              led_d = led_q << 1;
              if (led_d[WIDTH-1]) bdir_d = DOWN;
            end else begin
              led_d = led_q >> 1;
              if (led_d[0]) begin
                bdir_d = UP;
                wrap_d = 1'b1;
              end
            end
          end
          COUNT: begin
            if (dir) begin
              led_d  = led_q - 1'b1;
              wrap_d = (led_q == '0);
            end else begin
              led_d  = led_q + 1'b1;
              wrap_d = (led_q == ONES);
            end
          end
          FILL: begin
            k_d    = k_next;
            led_d  = fill_next;
            wrap_d = (k_next == '0);
          end
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= CHASE;
      bdir_q <= UP;
      cnt_q  <= '0;
      led_q  <= LSB;
      k_q    <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      bdir_q <= bdir_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      k_q    <= k_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus randomized stimulus,
// checked against a position/phase/value based reference model.
module tb_led_pattern_gen;
  localparam int W  = 8;
  localparam int TD = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic         dir = 1'b0;
  logic [1:0]   speed = 2'd0;
  logic         pause = 1'b0;
  logic [W-1:0] led;
  logic         step, wrap;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int           m_mode = 0, m_cnt = 0, m_pos = 0, m_phase = 0, m_val = 0, m_k = 0;
  logic [W-1:0] m_led = '0;
  logic         m_step = 1'b0, m_wrap = 1'b0;

  led_pattern_gen #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .mode(mode), .dir(dir), .speed(speed),
    .pause(pause), .led(led), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_advance();
    m_step = 1'b1;
    case (m_mode)
      0: begin
        if (!dir) begin
          m_wrap = (m_pos == W - 1);
          m_pos  = (m_pos + 1) % W;
        end else begin
          m_wrap = (m_pos == 0);
          m_pos  = (m_pos + W - 1) % W;
        end
        m_led = W'(1 << m_pos);
      end
      1: begin
        m_phase = (m_phase + 1) % (2 * (W - 1));
        m_wrap  = (m_phase == 0);
        m_led   = W'(1 << ((m_phase < W) ? m_phase : 2 * (W - 1) - m_phase));
      end
      2: begin
        if (!dir) begin
          m_val  = (m_val + 1) % (1 << W);
          m_wrap = (m_val == 0);
        end else begin
          m_val  = (m_val + (1 << W) - 1) % (1 << W);
          m_wrap = (m_val == (1 << W) - 1);
        end
        m_led = W'(m_val);
      end
      default: begin
        m_k    = (m_k + 1) % (W + 1);
        m_wrap = (m_k == 0);
        m_led  = dir ? W'((1 << W) - (1 << (W - m_k))) : W'((1 << m_k) - 1);
      end
    endcase
  endtask

  // Advance one clock edge and the model alongside it; returns 1 time unit later.
  task automatic cycle();
    int p;
    @(posedge clk);
    m_step = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_pos = 0; m_led = W'(1);
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cnt  = 0;
      case (m_mode)
        0: begin m_pos = dir ? W - 1 : 0; m_led = W'(1 << m_pos); end
        1: begin m_phase = 0; m_led = W'(1); end
        2: begin m_val = 0; m_led = '0; end
        default: begin m_k = 0; m_led = '0; end
      endcase
    end else if (!pause) begin
      p = TD >> speed;
      if (m_cnt >= p - 1) begin
        m_cnt = 0;
        model_advance();
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'd0; dir = 1'b0; speed = 2'd0; pause = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    total++;
    if (led !== 8'h01 || step !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset: got led=%h step=%b wrap=%b expected led=01 step=0 wrap=0", led, step, wrap);
    end
  endtask

  task automatic test_chase();
    int steps = 0, wraps = 0, first = -1;
    rst = 1'b1; mode = 2'd0; dir = 1'b0; speed = 2'd0; pause = 1'b0;
    cycle();
    rst = 1'b0;
    for (int i = 1; i <= 8 * TD; i++) begin
      cycle();
      total++;
      if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
        bad++;
        $display("FAIL chase_cycle: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                 led, step, wrap, m_led, m_step, m_wrap);
      end
      if (step) begin
        steps++;
        if (first < 0) first = i;
      end
      if (wrap) wraps++;
      if (i == TD) begin
        total++;
        if (led !== 8'h02 || step !== 1'b1) begin
          bad++;
          $display("FAIL chase_first: got led=%h step=%b expected led=02 step=1", led, step);
        end
      end
    end
    total++;
    if (first != TD || steps != 8 || wraps != 1) begin
      bad++;
      $display("FAIL chase_counts: got first=%0d steps=%0d wraps=%0d expected first=%0d steps=8 wraps=1",
               first, steps, wraps, TD);
    end
    total++;
    if (led !== 8'h01 || wrap !== 1'b1) begin
      bad++;
      $display("FAIL chase_wrap: got led=%h wrap=%b expected led=01 wrap=1", led, wrap);
    end
  endtask

  task automatic test_bounce();
    int s = 0, wrap_at = -1, wraps = 0;
    mode = 2'd1;
    cycle();
    total++;
    if (led !== 8'h01 || step !== 1'b0) begin
      bad++;
      $display("FAIL bounce_reload: got led=%h step=%b expected led=01 step=0", led, step);
    end
    for (int i = 1; i <= 14 * TD; i++) begin
      dir = 1'($urandom_range(0, 1));
      cycle();
      total++;
      if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
        bad++;
        $display("FAIL bounce_cycle: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                 led, step, wrap, m_led, m_step, m_wrap);
      end
      if (step) begin
        s++;
        if (s == 7) begin
          total++;
          if (led !== 8'h80) begin
            bad++;
            $display("FAIL bounce_top: got led=%h expected led=80", led);
          end
        end
      end
      if (wrap) begin
        wraps++;
        wrap_at = s;
      end
    end
    total++;
    if (wraps != 1 || wrap_at != 14 || led !== 8'h01) begin
      bad++;
      $display("FAIL bounce_wrap: got wraps=%0d at_step=%0d led=%h expected wraps=1 at_step=14 led=01",
               wraps, wrap_at, led);
    end
  endtask

  task automatic test_count_down();
    mode = 2'd2; dir = 1'b1;
    cycle();
    total++;
    if (led !== 8'h00 || step !== 1'b0) begin
      bad++;
      $display("FAIL count_reload: got led=%h step=%b expected led=00 step=0", led, step);
    end
    for (int i = 1; i <= 2 * TD; i++) begin
      cycle();
      total++;
      if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
        bad++;
        $display("FAIL count_cycle: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                 led, step, wrap, m_led, m_step, m_wrap);
      end
      if (i == TD || i == 2 * TD) begin
        total++;
        if (led !== ((i == TD) ? 8'hFF : 8'hFE) || wrap !== (i == TD)) begin
          bad++;
          $display("FAIL count_down_step: got led=%h wrap=%b at cycle %0d", led, wrap, i);
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_up[9] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] exp_dn[9] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    mode = 2'd3;
    for (int pass = 0; pass < 2; pass++) begin
      int s = 0;
      dir = (pass == 1);
      if (pass == 0) cycle();
      for (int i = 1; i <= 9 * TD; i++) begin
        cycle();
        total++;
        if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
          bad++;
          $display("FAIL fill_cycle: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                   led, step, wrap, m_led, m_step, m_wrap);
        end
        if (step) begin
          total++;
          if (led !== (pass == 1 ? exp_dn[s] : exp_up[s]) || wrap !== (s == 8)) begin
            bad++;
            $display("FAIL fill_step: got led=%h wrap=%b expected led=%h wrap=%b (dir=%b step %0d)",
                     led, wrap, (pass == 1 ? exp_dn[s] : exp_up[s]), (s == 8), dir, s + 1);
          end
          s++;
        end
      end
      total++;
      if (s != 9) begin
        bad++;
        $display("FAIL fill_count: got steps=%0d expected 9", s);
      end
    end
  endtask

  task automatic test_speed_pause();
    logic [W-1:0] hold;
    int n;
    rst = 1'b1; mode = 2'd0; dir = 1'b0; speed = 2'd0; pause = 1'b0;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    speed = 2'd3;
    cycle();
    total++;
    if (step !== 1'b1 || led !== 8'h02) begin
      bad++;
      $display("FAIL speed_immediate: got step=%b led=%h expected step=1 led=02", step, led);
    end
    cycle();
    total++;
    if (step !== 1'b0) begin
      bad++;
      $display("FAIL speed_gap: got step=%b expected 0", step);
    end
    cycle();
    total++;
    if (step !== 1'b1 || led !== 8'h04) begin
      bad++;
      $display("FAIL speed_period: got step=%b led=%h expected step=1 led=04", step, led);
    end
    hold = led;
    pause = 1'b1;
    repeat (5) begin
      cycle();
      total++;
      if (led !== hold || step !== 1'b0 || wrap !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold: got led=%h step=%b expected led=%h step=0", led, step, hold);
      end
    end
    pause = 1'b0;
    n = 5;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n++;
      if (step) break;
    end
    total++;
    if (n != 7 || led !== 8'h08) begin
      bad++;
      $display("FAIL pause_delay: got gap=%0d led=%h expected gap=7 led=08", n, led);
    end
  endtask

  task automatic test_reset_midop();
    int guard = 0;
    mode = 2'd2; dir = 1'b0; speed = 2'd3; pause = 1'b0;
    cycle();
    while (m_led != 8'h37 && guard < 400) begin
      cycle();
      guard++;
      total++;
      if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
        bad++;
        $display("FAIL midop_cycle: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                 led, step, wrap, m_led, m_step, m_wrap);
      end
    end
    total++;
    if (led !== 8'h37) begin
      bad++;
      $display("FAIL midop_reach: got led=%h expected 37", led);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++;
    if (led !== 8'h01 || step !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL midop_reset: got led=%h step=%b wrap=%b expected led=01 step=0 wrap=0", led, step, wrap);
    end
    pause = 1'b1;
    repeat (4) begin
      cycle();
      total++;
      if (led !== 8'h00 || step !== 1'b0) begin
        bad++;
        $display("FAIL paused_reload_count: got led=%h step=%b expected led=00 step=0", led, step);
      end
    end
    mode = 2'd0; dir = 1'b1;
    repeat (4) begin
      cycle();
      total++;
      if (led !== 8'h80 || step !== 1'b0) begin
        bad++;
        $display("FAIL paused_reload_chase: got led=%h step=%b expected led=80 step=0", led, step);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) speed = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
      cycle();
      total++;
      if ({led, step, wrap} !== {m_led, m_step, m_wrap}) begin
        bad++;
        $display("FAIL random_cycle %0d: got led=%h step=%b wrap=%b expected led=%h step=%b wrap=%b",
                 i, led, step, wrap, m_led, m_step, m_wrap);
      end
    end
    rst = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_chase();
    test_bounce();
    test_count_down();
    test_fill();
    test_speed_pause();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern sequencer for the board-level LED bank, and the successor to the fixed 8-LED chase counter. A prescaler divides the system clock into a step strobe. The prescale ratio is scaled at run time by a speed select, and the strobe can be paused. On each strobe the pattern advances in one of four selectable modes: chase, bounce, binary count and fill. The block drives the LED pins directly and exports step and wrap pulses for other logic.

## Interface
- WIDTH, 8, number of LEDs; legal range ≥ 2
- TICK_DIV, 10000000, base step period in clk cycles at speed 0; must be ≥ 16 and a multiple of 8
- clk  input  1  system clock (12 MHz on the board)
- rst  input  1  reset; synchronous and active-high
- mode  input  2  0 CHASE, 1 BOUNCE, 2 COUNT, 3 FILL
- dir  input  1  0 moves toward the MSB / counts up; 1 moves toward the LSB / counts down; ignored in BOUNCE
- speed  input  2  step period P = TICK_DIV >> speed
- pause  input  1  freezes the prescaler and the pattern while high
- led  output  WIDTH  pattern, registered
- step  output  1  one-cycle pulse, high in the cycle a new led value is first visible
- wrap  output  1  one-cycle pulse, high together with step when the pattern completes its cycle

## Operation
- Reset (synchronous) sets:
  - led = 1 (bit 0 only)
  - step = 0, wrap = 0
  - prescaler cnt = 0
  - registered mode mode_q = CHASE
  - bounce direction bdir = up
  - fill count k = 0
- Prescaler:
  - When pause = 0: if cnt ≥ P−1, set cnt ← 0 and strobe; otherwise cnt ← cnt+1.
  - The ≥ comparison makes a speed increase take effect at once: no strobe is missed and cnt never overruns.
  - When pause = 1, cnt, led and all internal state hold, and step/wrap stay 0.
- Mode change (mode ≠ mode_q) has priority over the strobe and is honoured even while paused. On that edge:
  - mode_q ← mode and cnt ← 0
  - led reloads to the start value; step and wrap stay 0
  - Start values: CHASE → bit 0 if dir = 0, bit WIDTH−1 if dir = 1. BOUNCE → bit 0 with bdir = up. COUNT → 0. FILL → 0 with k = 0.
- On each strobe, by mode:
  - CHASE: one-hot rotate, left when dir = 0, right when dir = 1. wrap fires when bit WIDTH−1 → bit 0 (dir 0) or bit 0 → bit WIDTH−1 (dir 1).
  - BOUNCE: one-hot shift in the bdir direction. On reaching bit WIDTH−1, bdir flips to down; on reaching bit 0, bdir flips to up. One cycle is 2·(WIDTH−1) steps. wrap fires on the step that lands on bit 0.
  - COUNT: led ± 1 modulo 2^WIDTH, direction set by dir. wrap fires on the transitions all-ones → 0 and 0 → all-ones.
  - FILL: k ← k+1 until k = WIDTH, then k ← 0. The thermometer has k ones: in the low bits when dir = 0, in the high bits when dir = 1. wrap fires on the step to k = 0. A cycle is WIDTH+1 steps.
- Changing dir mid-pattern does not reload. The next step uses the new dir from the current led (or current k in FILL).

## Timing
- Every output is registered, and led, step and wrap change on the same edge.
- After the last reset edge, or after a mode-change edge, the P-th following edge with pause = 0 produces the first step. Steps then recur every P unpaused edges.
- Pause high for N cycles delays the next step by exactly N cycles.
- Reset asserted mid-pattern overrides everything on that edge. The bench checks the reset values on the following cycle.
- Internal cnt width is $clog2(TICK_DIV). Width of k is $clog2(WIDTH+1).

## Test plan
- **Chase reset and wrap.** WIDTH=8, TICK_DIV=16, mode=0, dir=0, speed=0, rst pulsed for 1 cycle → led=0x01. First step on the 16th edge, led=0x02, then 0x04 … 0x80. The 8th step gives led=0x01 with wrap=1. step is high for exactly 1 cycle every 16.
- **Bounce.** Set mode=1 → led reloads to 0x01 with no step. Steps then give 0x02 … 0x80, 0x40 … 0x01, with wrap=1 only on step 14. dir toggling has no effect.
- **Count down.** Set mode=2, dir=1 → led reloads to 0x00. The next step gives 0xFF with wrap=1, then 0xFE.
- **Fill.** Set mode=3 with dir=0 → steps give 0x01, 0x03 … 0xFF, then 0x00 with wrap=1 on step 9. Repeat with dir=1 → 0x80, 0xC0 … 0xFF, 0x00.
- **Speed and pause.** Hold speed=0 until cnt=10, then set speed=3 (P=2) → step on the next edge, then every 2 cycles. Hold pause high for 5 cycles → led frozen, step=0, and the next step arrives 5 cycles late.
- **Reset and mode change mid-operation.** In COUNT at led=0x37, assert rst → next cycle led=0x01, step=0, wrap=0, mode treated as CHASE. Then change mode while pause=1 → led reloads to the start value and stays paused.
